// File: rtl/shared_resource_arbiter.sv
// shared_resource_arbiter
// Grants one shared resource to one of N requesters at a time. Each grant is
// registered and held until the owner releases it or withdraws its request,
// or until the hold watchdog expires. The winner is chosen by fixed priority
// (lowest index wins) or by round-robin from a rotating pointer. Between two
// owners there is always one cycle with no grant, so the resource mux never
// sees two grants at once.
module shared_resource_arbiter #(
    parameter int N       = 16,
    parameter int TIMEOUT = 255,
    parameter int CNTW    = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [N-1:0]         requestSignals,
    input  logic [N-1:0]         releaseSignals,
    input  logic                 rrMode,
    output logic [N-1:0]         grantSignals,
    output logic [$clog2(N)-1:0] grantIndex,
    output logic                 busy,
    output logic                 timeoutPulse
);

    localparam int IDXW = $clog2(N);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    // Hold-counter value on the last cycle a grant may stay visible.
    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [0:0]      state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            busy_q, busy_d;
    logic            tpulse_q, tpulse_d;
    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0] hold_cnt_q, hold_cnt_d;

    // Requests at or above the round-robin pointer.
    logic [N-1:0]    req_from_ptr;
    logic [IDXW-1:0] any_idx;
    logic [IDXW-1:0] ptr_idx;
    logic            ptr_found;
    logic [IDXW-1:0] winner;

    logic            owner_release;
    logic            owner_withdraw;
    logic            watchdog_hit;
    logic [IDXW-1:0] idx_plus_one;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ptr_mask
            assign req_from_ptr[gi] = requestSignals[gi] && (IDXW'(gi) >= rr_ptr_q);
        end
    endgenerate

    // Lowest set index overall and lowest set index at/above the RR pointer.
    always_comb begin
        any_idx   = '0;
        ptr_idx   = '0;
        ptr_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (requestSignals[i]) begin
                any_idx = IDXW'(i);
            end
            if (req_from_ptr[i]) begin
                ptr_idx   = IDXW'(i);
                ptr_found = 1'b1;
            end
        end
        winner = (rrMode && ptr_found) ? ptr_idx : any_idx;
    end

    assign owner_release  = releaseSignals[idx_q];
    assign owner_withdraw = !requestSignals[idx_q];
    assign watchdog_hit   = (TIMEOUT != 0) && (hold_cnt_q == HOLD_LAST);
    assign idx_plus_one   = (idx_q == IDXW'(N - 1)) ? '0 : idx_q + IDXW'(1);

    // Next-state logic for the grant/hold/release handshake.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        tpulse_d   = 1'b0;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|requestSignals) begin
                    state_d    = ST_OWNED;
                    grant_d    = N'(1) << winner;
                    idx_d      = winner;
                    busy_d     = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            ST_OWNED: begin
                if (owner_release || owner_withdraw || watchdog_hit) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    rr_ptr_d = idx_plus_one;
                    // A release or withdrawal on the same edge masks the timeout.
                    tpulse_d = !(owner_release || owner_withdraw);
                end else if (TIMEOUT != 0) begin
                    hold_cnt_d = hold_cnt_q + CNTW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any grant immediately.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            tpulse_q   <= 1'b0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            tpulse_q   <= tpulse_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign grantSignals = grant_q;
    assign grantIndex   = idx_q;
    assign busy         = busy_q;
    assign timeoutPulse = tpulse_q;

endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Testbench for shared_resource_arbiter: directed scenarios followed by random
// traffic. Each driven cycle pushes the expected post-edge outputs from a
// behavioural model; a monitor pops and compares after every rising edge.
module tb_shared_resource_arbiter;

    localparam int N       = 16;
    localparam int TIMEOUT = 8;
    localparam int CNTW    = 8;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  rel;
    logic          mode;
    logic [N-1:0]  grant;
    logic [3:0]    gidx;
    logic          busy;
    logic          tpulse;

    shared_resource_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
        .Clk            (clk),
        .Reset          (rst),
        .requestSignals (req),
        .releaseSignals (rel),
        .rrMode         (mode),
        .grantSignals   (grant),
        .grantIndex     (gidx),
        .busy           (busy),
        .timeoutPulse   (tpulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] g;
        logic [3:0]   idx;
        logic         b;
        logic         tp;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   txn   = 0;
    bit   stim_done = 0;

    // Behavioural model: who owns the resource, for how many cycles so far,
    // where round-robin search starts, and the last index handed out.
    int m_owner = -1;
    int m_age   = 0;
    int m_ptr   = 0;
    int m_last  = 0;

    function automatic int pick(input logic [N-1:0] rq, input logic m, input int p);
        int start;
        start = m ? p : 0;
        for (int k = 0; k < N; k++) begin
            if (rq[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    // Drive one cycle of inputs, advance the model, queue the expectation.
    task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] rl, input logic m);
        exp_t e;
        int   w;
        logic tp;
        @(negedge clk);
        rst  = r;
        req  = rq;
        rel  = rl;
        mode = m;
        tp   = 1'b0;
        if (r) begin
            m_owner = -1; m_age = 0; m_ptr = 0; m_last = 0;
        end else if (m_owner < 0) begin
            w = pick(rq, m, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_last = w; m_age = 1;
            end
        end else if (rl[m_owner] || !rq[m_owner]) begin
            m_ptr = (m_owner + 1) % N; m_owner = -1;
        end else if (TIMEOUT != 0 && m_age == TIMEOUT) begin
            m_ptr = (m_owner + 1) % N; m_owner = -1; tp = 1'b1;
        end else begin
            m_age++;
        end
        e.g   = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e.idx = 4'(m_last);
        e.b   = (m_owner >= 0);
        e.tp  = tp;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s txn=%0d actual=%0h required=%0h", name, txn, act, req_v);
        end
    endtask

    // Monitor: after every rising edge, compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                check("grant",   32'(grant),  32'(e.g));
                check("index",   32'(gidx),   32'(e.idx));
                check("busy",    32'(busy),   32'(e.b));
                check("timeout", 32'(tpulse), 32'(e.tp));
                if (!stim_done && (txn % 500 == 0 || txn <= 60))
                    $display("txn %0d: rst=%0b req=%04h rel=%04h rr=%0b -> grant=%04h idx=%0d busy=%0b to=%0b",
                             txn, rst, req, rel, mode, grant, gidx, busy, tpulse);
            end
        end
    end

    initial begin
        logic [N-1:0] rq;
        logic [N-1:0] rl;
        logic         m;
        rst = 1'b1; req = '0; rel = '0; mode = 1'b0;

        // Reset dominates a full request vector, then index 0 wins.
        repeat (3) step(1, 16'hFFFF, 0, 0);
        repeat (2) step(0, 16'hFFFF, 0, 0);

        // Fixed priority, no preemption, release then one idle cycle.
        step(1, 0, 0, 0);
        repeat (3) step(0, 16'h8010, 0, 0);
        repeat (2) step(0, 16'h8011, 0, 0);
        step(0, 16'h8011, 16'h0010, 0);
        repeat (3) step(0, 16'h8011, 0, 0);

        // Round-robin wrap: owner releases after holding two cycles.
        step(1, 0, 0, 1);
        for (int i = 0; i < 12; i++) begin
            rl = (m_owner >= 0 && m_age >= 2) ? (N'(1) << m_owner) : '0;
            step(0, 16'h8001, rl, 1);
        end

        // Watchdog expiry, then the next round-robin requester.
        step(1, 0, 0, 1);
        repeat (22) step(0, 16'h0028, 0, 1);

        // Release on the very edge the watchdog would fire.
        step(1, 0, 0, 0);
        repeat (8) step(0, 16'h0008, 0, 0);
        step(0, 16'h0008, 16'h0008, 0);
        repeat (2) step(0, 16'h0000, 0, 0);

        // Non-owner release ignored; withdrawal ends the grant.
        step(1, 0, 0, 0);
        repeat (3) step(0, 16'h0004, 0, 0);
        step(0, 16'h0004, 16'h0080, 0);
        step(0, 16'h0004, 0, 0);
        repeat (2) step(0, 16'h0000, 0, 0);
        step(0, 16'h0000, 16'h0001, 0);

        // Reset in the middle of an ownership clears the RR pointer.
        step(1, 0, 0, 1);
        repeat (4) step(0, 16'h0040, 0, 1);
        step(1, 16'h0041, 0, 1);
        repeat (3) step(0, 16'h0041, 0, 1);

        // Random traffic.
        rq = 16'(($urandom() & 32'hFFFF));
        m  = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 23) == 0) rq[b] = ~rq[b];
            if ($urandom_range(0, 49) == 0) m = ~m;
            rl = '0;
            if ($urandom_range(0, 3) == 0) begin
                if (m_owner >= 0 && $urandom_range(0, 1) == 1) rl[m_owner] = 1'b1;
                else rl[$urandom_range(0, N - 1)] = 1'b1;
            end
            step(($urandom_range(0, 299) == 0), rq, rl, m);
        end

        @(negedge clk);
        @(negedge clk);
        stim_done = 1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Structural invariants on every cycle after the first edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (!stim_done) begin
                check("onehot0", 32'($onehot0(grant)), 32'd1);
                check("busy_or", 32'(busy), 32'(|grant));
            end
        end
    end

endmodule
